// File: rtl/multicycle_control.sv
// Multi-cycle CPU control FSM: sequences fetch, decode, execute, memory and
// writeback, drives the datapath strobes and counts retired instructions.
// Optional feature macro: MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
//   defined   -> unknown Opcode/Funct enters TRAP (Illegal = 1 until reset)
//   undefined -> unknown Opcode/Funct retires as a NOP, Illegal tied to 0
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             IorD,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic [3:0]       ALUControl,
  output logic [3:0]       State,
  output logic             Illegal,
  output logic [CNT_W-1:0] RetiredCount
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTEXE   = 4'd6;
  localparam logic [3:0] S_RTWB    = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEXE = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
  localparam logic [3:0] S_TRAP    = 4'd12;
`endif

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  logic [3:0]       state_q, state_d;
  logic [3:0]       alu_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       funct_alu;
  logic             funct_ok;
  logic             retire;

  // Decode Funct into an ALU operation and flag unknown encodings.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    funct_alu = ALU_ADD;
    funct_ok  = 1'b1;
    case (Funct)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_SLT:  funct_alu = ALU_SLT;
      FN_NOR:  funct_alu = ALU_NOR;
      default: funct_ok  = 1'b0;
    endcase
  end

  // Next-state selection and retire detection (retire = leaving a final state).
  always_comb begin
    state_d = S_FETCH;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_RTYPE:      state_d = S_RTEXE;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_ADDI:       state_d = S_ADDIEXE;
          OP_J:          state_d = S_JUMP;
          default: begin
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
            state_d = S_TRAP;
`else
            state_d = S_FETCH;
            retire  = 1'b1;
`endif
          end
        endcase
      end
      S_MEMADR:  state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_MEMWB:   retire  = 1'b1;
      S_MEMWR:   retire  = 1'b1;
      S_RTEXE: begin
        if (funct_ok) begin
          state_d = S_RTWB;
        end else begin
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_FETCH;
          retire  = 1'b1;
`endif
        end
      end
      S_RTWB:    retire  = 1'b1;
      S_BRANCH:  retire  = 1'b1;
      S_ADDIEXE: state_d = S_ADDIWB;
      S_ADDIWB:  retire  = 1'b1;
      S_JUMP:    retire  = 1'b1;
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
      S_TRAP:    state_d = S_TRAP;
`endif
      default:   state_d = S_FETCH;
    endcase
  end

  // State, held R-type ALU op and retired counter; synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= S_FETCH;
      alu_q   <= ALU_ADD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_RTEXE) alu_q <= funct_alu;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Moore output decode; reset forces every strobe low.
  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemtoReg   = 1'b0;
    RegDst     = 1'b0;
    RegWrite   = 1'b0;
    IorD       = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSource   = 2'b00;
    ALUControl = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = 1'b1;
      end
      S_DECODE:  ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_RTEXE: begin
        ALUSrcA    = 1'b1;
        ALUControl = funct_alu;
      end
      S_RTWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        ALUControl = alu_q;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSource   = 2'b01;
        PCWrite    = Zero;
      end
      S_ADDIEXE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB:  RegWrite = 1'b1;
      S_JUMP: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      MemtoReg = 1'b0;
      RegDst   = 1'b0;
      RegWrite = 1'b0;
      IorD     = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      PCSource = 2'b00;
    end
  end

  assign State        = state_q;
  assign RetiredCount = cnt_q;
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
  assign Illegal = (state_q == S_TRAP) && !reset;
`else
  assign Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control (CNT_W = 4 to exercise wrap).
// Inputs change and outputs are sampled 1 ns after the falling clock edge.
module tb_multicycle_control;

  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic [5:0]       Opcode, Funct;
  logic             Zero;
  logic             PCWrite, IRWrite, MemRead, MemWrite, MemtoReg, RegDst;
  logic             RegWrite, IorD, ALUSrcA, Illegal;
  logic [1:0]       ALUSrcB, PCSource;
  logic [3:0]       ALUControl, State;
  logic [CNT_W-1:0] RetiredCount;

  int               n_checks = 0;
  int               n_fail   = 0;
  logic [CNT_W-1:0] exp_cnt  = '0;
  logic [16:0]      ctl;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .IorD(IorD),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUControl(ALUControl), .State(State), .Illegal(Illegal),
    .RetiredCount(RetiredCount)
  );

  always #5 clock = ~clock;

  // Packed control word: bits 16:4 are strobes/selects, 3:0 ALUControl.
  assign ctl = {PCWrite, IRWrite, MemRead, MemWrite, MemtoReg, RegDst, RegWrite,
                IorD, ALUSrcA, ALUSrcB, PCSource, ALUControl};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      6'b100111: return 4'b1100;
      default:   return 4'b0010;
    endcase
  endfunction

  // Expected control word per state, written from the state descriptions.
  // Order: PCW IRW MR MW M2R RD RW IorD SA SB[2] PCS[2] ALU[4]
  function automatic logic [16:0] exp_ctl(input logic [3:0] st, input logic [5:0] fn, input logic z);
    case (st)
      4'd0:  return {1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,4'b0010};
      4'd1:  return {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,4'b0010};
      4'd2:  return {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,4'b0010};
      4'd3:  return {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,4'b0010};
      4'd4:  return {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,4'b0010};
      4'd5:  return {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,4'b0010};
      4'd6:  return {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,alu_of(fn)};
      4'd7:  return {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,alu_of(fn)};
      4'd8:  return {z,   1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,4'b0110};
      4'd9:  return {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,4'b0010};
      4'd10: return {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,4'b0010};
      4'd11: return {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,4'b0010};
      default: return {13'd0, 4'b0010};
    endcase
  endfunction

  // Run one instruction from FETCH, checking n states (seq nibble 0 first),
  // then expect FETCH again with the counter advanced by one.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int n, input logic [23:0] seq);
    logic [3:0] st;
    Opcode = op; Funct = fn; Zero = z;
    #1;
    for (int i = 0; i < n; i++) begin
      st = seq[4*i +: 4];
      check($sformatf("%s c%0d state", name, i+1), 32'(State), 32'(st));
      check($sformatf("%s c%0d ctl", name, i+1), 32'(ctl), 32'(exp_ctl(st, fn, z)));
      check($sformatf("%s c%0d illegal", name, i+1), 32'(Illegal), 32'd0);
      @(negedge clock); #1;
    end
    exp_cnt = exp_cnt + 1'b1;
    check({name, " back to fetch"}, 32'(State), 32'd0);
    check({name, " retired"}, 32'(RetiredCount), 32'(exp_cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; Opcode = 6'b000000; Funct = 6'b100000; Zero = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check("reset state", 32'(State), 32'd0);
    check("reset count", 32'(RetiredCount), 32'd0);
    check("reset illegal", 32'(Illegal), 32'd0);
    check("reset strobes", 32'(ctl[16:4]), 32'd0);
    reset = 1'b0;

    run_instr("radd",  6'b000000, 6'b100000, 1'b0, 4, 24'(16'h7610));
    run_instr("lw",    6'b100011, 6'b100000, 1'b0, 5, 24'(20'h43210));
    run_instr("sw",    6'b101011, 6'b100000, 1'b0, 4, 24'(16'h5210));
    run_instr("beq_z1",6'b000100, 6'b100000, 1'b1, 3, 24'(12'h810));
    run_instr("beq_z0",6'b000100, 6'b100000, 1'b0, 3, 24'(12'h810));
    run_instr("addi",  6'b001000, 6'b100000, 1'b0, 4, 24'(16'hA910));
    run_instr("slt",   6'b000000, 6'b101010, 1'b0, 4, 24'(16'h7610));
    run_instr("nor",   6'b000000, 6'b100111, 1'b0, 4, 24'(16'h7610));
    run_instr("sub",   6'b000000, 6'b100010, 1'b0, 4, 24'(16'h7610));
    run_instr("and",   6'b000000, 6'b100100, 1'b0, 4, 24'(16'h7610));
    run_instr("or",    6'b000000, 6'b100101, 1'b0, 4, 24'(16'h7610));

    // Reset asserted while in MEMRD: no retire, count cleared.
    Opcode = 6'b100011; Funct = 6'b100000;
    repeat (3) @(negedge clock);
    #1;
    check("lw_rst in memrd", 32'(State), 32'd3);
    reset = 1'b1;
    #1;
    check("lw_rst strobes low", 32'(ctl[16:4]), 32'd0);
    @(negedge clock); #1;
    check("lw_rst state", 32'(State), 32'd0);
    check("lw_rst count", 32'(RetiredCount), 32'd0);
    exp_cnt = '0;
    reset = 1'b0;

    // Sixteen jumps wrap the 4-bit counter back to zero.
    for (int k = 0; k < 16; k++)
      run_instr($sformatf("j%0d", k), 6'b000010, 6'b100000, 1'b0, 3, 24'(12'hB10));
    check("wrap to zero", 32'(RetiredCount), 32'd0);

`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
    Opcode = 6'b111111; Funct = 6'b100000;
    #1;
    check("bad_op fetch", 32'(State), 32'd0);
    @(negedge clock); #1;
    check("bad_op decode", 32'(State), 32'd1);
    @(negedge clock); #1;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("trap%0d state", k), 32'(State), 32'd12);
      check($sformatf("trap%0d illegal", k), 32'(Illegal), 32'd1);
      check($sformatf("trap%0d strobes", k), 32'(ctl[16:4]), 32'd0);
      check($sformatf("trap%0d count", k), 32'(RetiredCount), 32'(exp_cnt));
      @(negedge clock); #1;
    end
    reset = 1'b1;
    @(negedge clock); #1;
    check("trap reset state", 32'(State), 32'd0);
    check("trap reset illegal", 32'(Illegal), 32'd0);
    reset = 1'b0; exp_cnt = '0;

    Opcode = 6'b000000; Funct = 6'b111111;
    repeat (3) @(negedge clock);
    #1;
    check("bad_fn trap state", 32'(State), 32'd12);
    check("bad_fn illegal", 32'(Illegal), 32'd1);
    check("bad_fn count", 32'(RetiredCount), 32'(exp_cnt));
    reset = 1'b1;
    @(negedge clock); #1;
    check("bad_fn reset state", 32'(State), 32'd0);
    reset = 1'b0;
`else
    run_instr("bad_op", 6'b111111, 6'b100000, 1'b0, 2, 24'(8'h10));
    run_instr("bad_fn", 6'b000000, 6'b111111, 1'b0, 3, 24'(12'h610));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control FSM sitting directly upstream of the CPU datapath.
- Consumes Opcode and Funct from the fetched instruction, and Zero from the ALU.
- Produces the per-cycle control strobes that sequence fetch, decode, execute, memory and writeback over several clock cycles, including ALUControl and RegWrite.
- Also keeps a retired-instruction counter for bring-up and benchmarking.

Parameters:
CNT_W, 32, width of the retired-instruction counter.

Ports:
clock  input  1  system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
Opcode  input  6  instruction bits [31:26].
Funct  input  6  instruction bits [5:0].
Zero  input  1  ALU zero flag.
PCWrite  output  1  load PC.
IRWrite  output  1  load instruction register.
MemRead  output  1  memory read enable.
MemWrite  output  1  memory write enable.
MemtoReg  output  1  register write data: 1 = memory data register, 0 = ALU out.
RegDst  output  1  write address: 1 = rd, 0 = rt.
RegWrite  output  1  register file write enable.
IorD  output  1  memory address: 1 = ALU out, 0 = PC.
ALUSrcA  output  1  ALU A input: 0 = PC, 1 = rdA.
ALUSrcB  output  2  ALU B input: 00 = rdB, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
PCSource  output  2  PC source: 00 = ALU result, 01 = ALU out register, 10 = jump target.
ALUControl  output  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
State  output  4  current state, for debug.
Illegal  output  1  illegal-instruction flag.
RetiredCount  output  CNT_W  number of completed instructions.

Behaviour:
- Reset: State = FETCH (0); RetiredCount = 0; Illegal = 0. All strobes are forced to 0 while reset is high.
- Outputs are Moore, decoded from State. The only exception is PCWrite in BRANCH, which also depends on Zero.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEXE 6, RTWB 7, BRANCH 8, ADDIEXE 9, ADDIWB 10, JUMP 11, TRAP 12.
- FETCH: MemRead, IRWrite, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ADD, PCSource = 00, PCWrite. Next state: DECODE.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ADD (precomputes branch target). Next state by Opcode:
  - 000000 (R-type) -> RTEXE
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEXE
  - 000010 (j) -> JUMP
  - anything else -> illegal handling (see Optional Feature).
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, ADD. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: MemRead, IorD = 1. Next: MEMWB.
- MEMWB: RegWrite, MemtoReg = 1, RegDst = 0. Next: FETCH; retire.
- MEMWR: MemWrite, IorD = 1. Next: FETCH; retire.
- RTEXE: ALUSrcA = 1, ALUSrcB = 00. ALUControl from Funct:
  - 100000 -> ADD; 100010 -> SUB; 100100 -> AND; 100101 -> OR; 101010 -> SLT; 100111 -> NOR.
  - Next: RTWB for a known Funct. An unknown Funct is illegal.
- RTWB: RegWrite, RegDst = 1, MemtoReg = 0, and ALUControl is held at the RTEXE value. Next: FETCH; retire.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, SUB, PCSource = 01, PCWrite = Zero. Next: FETCH; retire regardless of Zero.
- ADDIEXE: ALUSrcA = 1, ALUSrcB = 10, ADD. Next: ADDIWB.
- ADDIWB: RegWrite, RegDst = 0, MemtoReg = 0. Next: FETCH; retire.
- JUMP: PCSource = 10, PCWrite. Next: FETCH; retire.
- Latencies, FETCH to FETCH: lw 5 cycles; R-type, sw, addi 4 cycles; beq, j 3 cycles.
- Retire: RetiredCount increments by 1 on the edge that leaves a final state. It wraps modulo 2^CNT_W with no saturation.
- Unused strobes are 0 in every state. The default ALUControl is ADD.
- Reset asserted mid-instruction takes effect on the next edge: State goes to FETCH and the count clears. A partially executed instruction does not retire.

Optional Feature:
- Macro: MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN.
- Defined: an unknown Opcode in DECODE, or an unknown Funct in RTEXE, moves to TRAP.
  - In TRAP all strobes are 0 and Illegal = 1, held until reset.
  - No retire occurs.
- Undefined: the TRAP state is not compiled.
  - An unknown Opcode or Funct returns to FETCH with no register or memory write and retires as a NOP.
  - Illegal is tied to 0.

Test Plan:
- Reset then release with Opcode = 000000, Funct = 100000: State sequence 0,1,6,7,0. RegWrite = 1 with RegDst = 1 only in cycle 4. RetiredCount = 1.
- lw (100011): State sequence 0,1,2,3,4,0. MemRead in cycles 1 and 4, with IorD = 1 in cycle 4. RegWrite with MemtoReg = 1 in cycle 5. No MemWrite.
- beq (000100) with Zero = 1, then repeated with Zero = 0: 3-cycle sequence 0,1,8. PCWrite in BRANCH is 1 and 0 respectively. RetiredCount increments in both cases.
- Funct = 101010: ALUControl = 0111 in RTEXE and RTWB. Funct = 100111: ALUControl = 1100.
- Opcode = 111111 with the macro defined: State = 12 and Illegal = 1 held for 10 cycles. Reset -> State = 0, Illegal = 0. Same stimulus with the macro undefined: back to FETCH after DECODE, no strobes, RetiredCount + 1.
- CNT_W = 4: run 16 j instructions -> RetiredCount wraps to 0. Assert reset during MEMRD -> next State = 0, RetiredCount = 0.
